// File: rtl/sequence_detector_pkg.sv
// -----------------------------------------------------------------------------
// sequence_detector_pkg
// Shared definitions for the serial pattern detector:
//   - state_t : FSM state enum, 4-bit encoding (8 legal codes, 8 illegal)
//   - PAT1    : first pattern, 1,0,0,1 (MSB is the oldest bit)
//   - PAT2    : second pattern, 0,1,0 (MSB is the oldest bit)
//   - is_hit  : true for the two states that assert the detection flag
// -----------------------------------------------------------------------------
package sequence_detector_pkg;

  localparam logic [3:0] PAT1 = 4'b1001;
  localparam logic [2:0] PAT2 = 3'b010;

  // Each state names the longest stream suffix that is still a prefix of
  // either pattern. The two hit states double as the overlap prefix they
  // leave behind ("01" after 1001, "10" after 010).
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    S0    = 4'd1,
    S1    = 4'd2,
    S01   = 4'd3,
    S10   = 4'd4,
    S100  = 4'd5,
    H1001 = 4'd6,
    H010  = 4'd7
  } state_t;

  function automatic logic is_hit(input state_t s);
    return (s == H1001) || (s == H010);
  endfunction

endpackage

// File: rtl/sequence_detector_if.sv
// -----------------------------------------------------------------------------
// sequence_detector_if
// Serial data line into the detector and the detection flag out of it.
//   in  : serial data bit, one per rising clock edge
//   out : detection flag, high for one cycle per pattern hit
// Modports:
//   master : stream source / flag consumer (drives in, reads out)
//   slave  : the detector (reads in, drives out)
// -----------------------------------------------------------------------------
interface sequence_detector_if;
  logic in;
  logic out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/sequence_detector.sv
// -----------------------------------------------------------------------------
// sequence_detector
// Moore FSM that flags every occurrence of 1001 and 010 on a serial bit
// stream, overlaps allowed. The flag is registered: it rises on the edge that
// samples the final pattern bit and has no combinational path from the input.
// Ports:
//   clk  : single clock, rising edge
//   rstn : asynchronous active-low reset; clears history and flag at once
//   bus  : sequence_detector_if.slave (in = serial bit, out = detection flag)
// -----------------------------------------------------------------------------
module sequence_detector
  import sequence_detector_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  sequence_detector_if.slave  bus
);

  state_t r_state;
  state_t w_state_next;
  logic   r_out;

  // Next-state table. Any encoding outside the eight legal states falls into
  // the default branch and recovers to IDLE on the next edge.
  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = bus.in ? S1    : S0;
      S0:      w_state_next = bus.in ? S01   : S0;
      S1:      w_state_next = bus.in ? S1    : S10;
      S01:     w_state_next = bus.in ? S1    : H010;
      S10:     w_state_next = bus.in ? S01   : S100;
      S100:    w_state_next = bus.in ? H1001 : S0;
      H1001:   w_state_next = bus.in ? S1    : H010;   // behaves as "01"
      H010:    w_state_next = bus.in ? S01   : S100;   // behaves as "10"
      default: w_state_next = IDLE;
    endcase
  end

  // The flag register is loaded from the decode of the next state so that it
  // always equals is_hit(r_state) while staying a flop output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= is_hit(w_state_next);
    end
  end

  assign bus.out = r_out;

endmodule

// File: tb/tb_sequence_detector.sv
module tb_sequence_detector;
  import sequence_detector_pkg::*;

  logic clk;
  logic clk_en;
  logic rstn;

  sequence_detector_if bus_if ();

  sequence_detector dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int   n_vec;
  int   n_err;
  logic sb_q[$];

  // Reference model: raw bit history plus count of bits since reset.
  logic [3:0] hist;
  int         nbits;

  function automatic logic predict(input logic [3:0] h, input int n);
    logic [2:0] h3;
    h3 = h[2:0];
    return ((n >= 4) && (h == PAT1)) || ((n >= 3) && (h3 == PAT2));
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input logic e, input string tag);
    logic exp;
    @(negedge clk);
    bus_if.in = b;
    sb_q.push_back(e);
    hist = {hist[2:0], b};
    if (nbits < 4) nbits++;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      exp = sb_q.pop_front();
      $display("bit=%b out=%b exp=%b (%s)", b, bus_if.out, exp, tag);
      check(tag, bus_if.out, exp);
    end
  endtask

  task automatic drive_model(input logic b, input string tag);
    logic [3:0] h;
    int         n;
    h = {hist[2:0], b};
    n = (nbits < 4) ? nbits + 1 : 4;
    drive(b, predict(h, n), tag);
  endtask

  // Reset pulse placed between edges; flag must drop without a clock.
  task automatic pulse_reset(input string tag);
    #1 rstn = 1'b0;
    #1 check(tag, bus_if.out, 1'b0);
    $display("reset pulse out=%b (%s)", bus_if.out, tag);
    #1 rstn = 1'b1;
    hist  = 4'b0;
    nbits = 0;
  endtask

  task automatic drive_vec(input logic [15:0] bits, input logic [15:0] exps,
                           input int len, input string tag);
    for (int i = 0; i < len; i++) drive(bits[i], exps[i], tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    hist      = 4'b0;
    nbits     = 0;
    clk_en    = 1'b0;
    rstn      = 1'b1;
    bus_if.in = 1'b0;

    // Asynchronous reset with the clock stopped.
    #1 rstn = 1'b0;
    #1 check("reset_noclk", bus_if.out, 1'b0);
    $display("reset no clock out=%b", bus_if.out);

    // Hold reset across three edges with the input toggling.
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.in = i[0];
      @(posedge clk);
      #1 check("reset_hold", bus_if.out, 1'b0);
      $display("reset hold edge %0d out=%b", i, bus_if.out);
    end
    @(negedge clk);
    rstn = 1'b1;

    // 16'h692A, LSB first.
    drive_vec(16'h692A, 16'b0001_1011_0101_0100, 16, "stream_692A");

    // Isolated P1, then two ones.
    pulse_reset("reset_a");
    drive_vec(16'b0000_0000_0011_1001, 16'b0000_0000_0000_1000, 6, "iso_p1");

    // Non-matching runs.
    pulse_reset("reset_b");
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, "run_zeros");
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, "run_ones");

    // Overlap chain 1,0,0,1,0,0,1 -> 0,0,0,1,1,0,1.
    pulse_reset("reset_c");
    drive_vec(16'b0000_0000_0100_1001, 16'b0000_0000_0101_1000, 7, "overlap");

    // Reset while sitting in a hit state drops the flag at once.
    pulse_reset("reset_in_hit");

    // Prefix 1,0,0 discarded by reset; the following 1 must not hit.
    drive_vec(16'b0000_0000_0000_0001, 16'h0000, 3, "prefix_100");
    pulse_reset("reset_mid");
    drive(1'b1, 1'b0, "after_reset");

    // Random stream checked against the history model.
    for (int i = 0; i < 200; i++) drive_model(1'($urandom_range(0, 1)), "random");

    check("sb_drained", 1'(sb_q.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
